// File: rtl/dkong_dn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dkong_dn_pkg                                                         |
// | Shared state encoding and default sizing for the ROM download loader |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dkong_dn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } dn_state_t;

  localparam int              DN_AW       = 19;
  localparam logic [DN_AW-1:0] DN_EXP_SIZE = 19'h40000;
  localparam int              DN_HOLD_CYC = 16;

endpackage
`default_nettype wire

// File: rtl/dkong_dn_csum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dkong_dn_csum                                                        |
// | 16-bit modulo byte-sum accumulator with clear and add-enable         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dkong_dn_csum
  import dkong_dn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_add,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_sum
);

  logic [15:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sum <= 16'h0000;
    end else if (i_add) begin
      r_sum <= r_sum + {8'h00, i_byte};
    end
  end

  assign o_sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/dkong_dn_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dkong_dn_loader                                                      |
// | Framed byte stream to dpram write port; holds core reset while      |
// | loading. Optional checksum: define DKONG_DN_CSUM_EN.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dkong_dn_loader
  import dkong_dn_pkg::*;
#(
  parameter int          AW       = DN_AW,
  parameter logic [AW-1:0] EXP_SIZE = AW'(DN_EXP_SIZE),
  parameter int          WR_GAP   = 0,
  parameter int          HOLD_CYC = DN_HOLD_CYC,
  parameter logic [15:0] EXP_CSUM = 16'h0000
)(
  input  logic          I_CLK_24576M,
  input  logic          I_RST,
  input  logic          I_DL_ACT,
  input  logic [7:0]    I_DL_D,
  input  logic          I_DL_VALID,
  output logic          O_DL_READY,
  output logic [AW-1:0] O_DN_ADDR,
  output logic [7:0]    O_DN_DATA,
  output logic          O_DN_WR,
  output logic          O_CORE_RESETn,
  output logic          O_DONE,
  output logic          O_ERR,
  output logic [15:0]   O_CSUM
);

  dn_state_t     r_state, w_state_nxt;
  logic          r_act_d;
  logic [AW-1:0] r_cnt, r_addr;
  logic [7:0]    r_data;
  logic          r_wr, r_ovf, r_err, r_done, r_rstn;
  logic [15:0]   r_gap, r_hold;
  logic [15:0]   w_sum;
  logic          w_act_rise, w_act_fall, w_ready, w_accept, w_room, w_wr_en;
  logic          w_hold_last, w_err_now;

  assign w_act_rise  = I_DL_ACT & ~r_act_d;
  assign w_act_fall  = ~I_DL_ACT & r_act_d;
  assign w_ready     = (r_state == ST_LOAD) && (r_gap == 16'd0);
  assign w_accept    = I_DL_VALID & w_ready;
  assign w_room      = (r_cnt < EXP_SIZE);
  assign w_wr_en     = w_accept & w_room;
  assign w_hold_last = (32'(r_hold) + 32'd1) >= 32'(HOLD_CYC);

`ifdef DKONG_DN_CSUM_EN
  dkong_dn_csum u_csum (
    .clk    (I_CLK_24576M),
    .rst    (I_RST),
    .i_clr  (w_act_rise),
    .i_add  (w_wr_en),
    .i_byte (I_DL_D),
    .o_sum  (w_sum)
  );
  assign w_err_now = (r_cnt != EXP_SIZE) | r_ovf | (w_sum != EXP_CSUM);
`else
  logic w_unused_csum;
  assign w_unused_csum = ^EXP_CSUM;
  assign w_sum         = 16'h0000;
  assign w_err_now     = (r_cnt != EXP_SIZE) | r_ovf;
`endif

  always_ff @(posedge I_CLK_24576M) begin
    if (I_RST) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A rising frame edge restarts the load from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (w_act_rise) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: if (w_act_fall)  w_state_nxt = ST_HOLD;
        ST_HOLD: if (w_hold_last) w_state_nxt = ST_DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge I_CLK_24576M) begin
    if (I_RST) begin
      r_act_d <= I_DL_ACT;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= 8'h00;
      r_wr    <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_rstn  <= 1'b0;
      r_gap   <= 16'd0;
      r_hold  <= 16'd0;
    end else begin
      r_act_d <= I_DL_ACT;
      r_wr    <= 1'b0;
      if (w_act_rise) begin
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
        r_err  <= 1'b0;
        r_done <= 1'b0;
        r_rstn <= 1'b0;
        r_gap  <= 16'd0;
        r_hold <= 16'd0;
      end else begin
        if (w_accept) begin
          r_gap <= 16'(WR_GAP);
          if (w_room) begin
            r_wr   <= 1'b1;
            r_addr <= r_cnt;
            r_data <= I_DL_D;
            r_cnt  <= r_cnt + 1'b1;
          end else begin
            r_ovf <= 1'b1;
          end
        end else if (r_gap != 16'd0) begin
          r_gap <= r_gap - 16'd1;
        end
        // The count is final by the first HOLD cycle, so latching every cycle is stable.
        if (r_state == ST_HOLD) begin
          r_err  <= w_err_now;
          r_hold <= r_hold + 16'd1;
          if (w_hold_last) begin
            r_rstn <= 1'b1;
            r_done <= 1'b1;
          end
        end
      end
    end
  end

  assign O_DL_READY    = w_ready;
  assign O_DN_ADDR     = r_addr;
  assign O_DN_DATA     = r_data;
  assign O_DN_WR       = r_wr;
  assign O_CORE_RESETn = r_rstn;
  assign O_DONE        = r_done;
  assign O_ERR         = r_err;
  assign O_CSUM        = w_sum;

endmodule
`default_nettype wire

// File: tb/tb_dkong_dn_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dkong_dn_loader                                                   |
// | Scoreboard bench: driver queues expected writes, monitors compare    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dkong_dn_loader;

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_act, a_valid;
  logic [7:0]  a_d;
  logic        a_ready, a_wr, a_rstn, a_done, a_err;
  logic [18:0] a_addr;
  logic [7:0]  a_data;
  logic [15:0] a_csum;
  logic        b_act, b_valid;
  logic [7:0]  b_d;
  logic        b_ready, b_wr, b_rstn, b_done, b_err;
  logic [18:0] b_addr;
  logic [7:0]  b_data;
  logic [15:0] b_csum;

  int          tests  = 0;
  int          failed = 0;
  int          cyc    = 0;
  wr_t         qa[$];
  wr_t         qb[$];
  int          m_cnt, m_acc;
  logic [15:0] m_sum;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dkong_dn_loader #(.AW(19), .EXP_SIZE(19'd4), .WR_GAP(0), .HOLD_CYC(16), .EXP_CSUM(16'h01FF)) u_dut_a (
    .I_CLK_24576M(clk), .I_RST(rst), .I_DL_ACT(a_act), .I_DL_D(a_d), .I_DL_VALID(a_valid),
    .O_DL_READY(a_ready), .O_DN_ADDR(a_addr), .O_DN_DATA(a_data), .O_DN_WR(a_wr),
    .O_CORE_RESETn(a_rstn), .O_DONE(a_done), .O_ERR(a_err), .O_CSUM(a_csum)
  );

  dkong_dn_loader #(.AW(19), .EXP_SIZE(19'd4), .WR_GAP(2), .HOLD_CYC(16), .EXP_CSUM(16'h0000)) u_dut_b (
    .I_CLK_24576M(clk), .I_RST(rst), .I_DL_ACT(b_act), .I_DL_D(b_d), .I_DL_VALID(b_valid),
    .O_DL_READY(b_ready), .O_DN_ADDR(b_addr), .O_DN_DATA(b_data), .O_DN_WR(b_wr),
    .O_CORE_RESETn(b_rstn), .O_DONE(b_done), .O_ERR(b_err), .O_CSUM(b_csum)
  );

  function automatic logic [15:0] ecs(input logic [15:0] s);
`ifdef DKONG_DN_CSUM_EN
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write monitors: every strobe must match the head of its queue, including cycle.
  always @(negedge clk) begin
    if (a_wr === 1'b1) begin
      tests++;
      if (qa.size() == 0) begin
        failed++;
        $display("FAIL a_wr_unexpected: got addr %0h data %0h expected no write", a_addr, a_data);
      end else begin
        wr_t e;
        e = qa.pop_front();
        if (a_addr !== e.addr || a_data !== e.data || cyc != e.cyc) begin
          failed++;
          $display("FAIL a_wr: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                   a_addr, a_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_wr === 1'b1) begin
      tests++;
      if (qb.size() == 0) begin
        failed++;
        $display("FAIL b_wr_unexpected: got addr %0h data %0h expected no write", b_addr, b_data);
      end else begin
        wr_t e;
        e = qb.pop_front();
        if (b_addr !== e.addr || b_data !== e.data || cyc != e.cyc) begin
          failed++;
          $display("FAIL b_wr: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                   b_addr, b_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic frame_start();
    a_act = 1'b1;
    m_cnt = 0; m_acc = 0; m_sum = 16'h0000;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit last);
    int t;
    t = 0;
    a_valid = 1'b1;
    a_d     = b;
    if (last) a_act = 1'b0;
    while (a_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      chk("accept_timeout", {31'd0, a_ready}, 32'd1);
    end else begin
      if (m_cnt < 4) begin
        qa.push_back('{addr: 19'(m_cnt), data: b, cyc: cyc + 1});
        m_sum = m_sum + {8'h00, b};
        m_cnt++;
      end
      m_acc++;
    end
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (a_done !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("done_wait", {31'd0, a_done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; a_act = 1'b0; a_valid = 1'b0; a_d = 8'h00;
    b_act = 1'b0; b_valid = 1'b0; b_d = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_addr_data", {5'd0, a_addr, a_data}, 32'd0);
    chk("rst_wr", {31'd0, a_wr}, 32'd0);
    chk("rst_rstn_done_err", {29'd0, a_rstn, a_done, a_err}, 32'd0);
    chk("rst_csum", {16'd0, a_csum}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Gap: ready 1 cycle in 3, writes spaced 3 cycles apart.
    b_act = 1'b1;
    @(negedge clk);
    b_valid = 1'b1; b_d = 8'h5A;
    for (int i = 0; i < 9; i++) begin
      chk("gap_ready", {31'd0, b_ready}, (i % 3 == 0) ? 32'd1 : 32'd0);
      if (i % 3 == 0) qb.push_back('{addr: 19'(i / 3), data: 8'h5A, cyc: cyc + 1});
      @(negedge clk);
    end
    b_valid = 1'b0; b_act = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal load, last byte accepted in the act_fall cycle.
    frame_start();
    send(8'hAA, 1'b0);
    send(8'h55, 1'b0);
    send(8'h01, 1'b0);
    send(8'hFF, 1'b1);
    chk("nom_ready_drop", {31'd0, a_ready}, 32'd0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 2) chk("nom_err_hold", {31'd0, a_err}, 32'd0);
    end
    chk("nom_rstn_before", {30'd0, a_rstn, a_done}, 32'd0);
    @(negedge clk);
    chk("nom_rstn_at16", {30'd0, a_rstn, a_done}, 32'd3);
    chk("nom_err", {31'd0, a_err}, 32'd0);
    chk("nom_csum", {16'd0, a_csum}, {16'd0, ecs(16'h01FF)});

    // Reload from DONE, then a short image.
    frame_start();
    chk("reload_rstn_done", {30'd0, a_rstn, a_done}, 32'd0);
    chk("reload_csum", {16'd0, a_csum}, 32'd0);
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b1);
    @(negedge clk);
    chk("short_err_hold", {30'd0, a_err, a_done}, 32'd2);
    wait_done();
    chk("short_err_done", {30'd0, a_err, a_rstn}, 32'd3);
    chk("short_csum", {16'd0, a_csum}, {16'd0, ecs(16'h0060)});

    // Overflow: six bytes into a four-byte image.
    frame_start();
    for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
    chk("ovf_accepts", 32'(m_acc), 32'd6);
    wait_done();
    chk("ovf_err", {31'd0, a_err}, 32'd1);
    chk("ovf_csum", {16'd0, a_csum}, {16'd0, ecs(16'h000A)});

    // Reset mid-load abandons the image; next frame restarts at address 0.
    frame_start();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_addr_data", {5'd0, a_addr, a_data}, 32'd0);
    chk("mid_rst_wr_ready", {30'd0, a_wr, a_ready}, 32'd0);
    chk("mid_rst_flags", {29'd0, a_rstn, a_done, a_err}, 32'd0);
    chk("mid_rst_csum", {16'd0, a_csum}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_no_edge", {31'd0, a_ready}, 32'd0);
    a_act = 1'b0;
    @(negedge clk);
    frame_start();
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    wait_done();
    chk("restart_err", {31'd0, a_err}, 32'd1);

    repeat (3) @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
